// File: rtl/game_text_render.sv
// Text-box overlay stage: looks up a 16x4 character grid and an 8x16 font, then paints the
// glyph pixels over the incoming VGA stream with a 4-clock latency and a blinking row highlight.
module game_text_render #(
    parameter logic [10:0] X_POS        = 11'd256,
    parameter logic [10:0] Y_POS        = 11'd200,
    parameter logic [11:0] TXT_COLOR    = 12'hFFF,
    parameter logic [11:0] HL_COLOR     = 12'hFF0,
    parameter logic [5:0]  BLINK_FRAMES = 6'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [1:0]  sel_row,
    input  logic        sel_en,
    output logic [7:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  char_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Only the low bits of the box-relative offsets are ever used, so the subtraction is
    // done at that width; membership itself is decided on the full raw counts.
    logic [6:0]  w_dx;
    logic [5:0]  w_dy;
    logic        w_in_box;
    logic [25:0] w_sync_in;
    logic        w_vs_rise;
    logic        w_glyph_bit;
    logic        w_blank;
    logic [11:0] w_rgb_next;

    logic        r_in_box_d1, r_in_box_d2, r_in_box_d3;
    logic [2:0]  r_rel_x_d1, r_rel_x_d2, r_rel_x_d3;
    logic [1:0]  r_row_d1, r_row_d2, r_row_d3;
    logic [3:0]  r_line_d1, r_line_d2;
    logic [7:0]  r_char_xy;
    logic [25:0] r_sync_d1, r_sync_d2, r_sync_d3, r_sync_d4;
    logic [11:0] r_rgb_d1, r_rgb_d2, r_rgb_d3;
    logic [11:0] r_rgb_out;

    logic        r_vsync_q;
    logic [5:0]  r_frame_cnt;
    logic        r_blink_phase;
    logic [1:0]  r_hl_row;
    logic        r_hl_en;

    assign w_dx = hcount_in[6:0] - X_POS[6:0];
    assign w_dy = vcount_in[5:0] - Y_POS[5:0];

    assign w_in_box = ({1'b0, hcount_in} >= {1'b0, X_POS}) &&
                      ({1'b0, hcount_in} <  ({1'b0, X_POS} + 12'd128)) &&
                      ({1'b0, vcount_in} >= {1'b0, Y_POS}) &&
                      ({1'b0, vcount_in} <  ({1'b0, Y_POS} + 12'd64));

    assign w_sync_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_box_d1 <= 1'b0;
            r_in_box_d2 <= 1'b0;
            r_in_box_d3 <= 1'b0;
            r_rel_x_d1  <= 3'd0;
            r_rel_x_d2  <= 3'd0;
            r_rel_x_d3  <= 3'd0;
            r_row_d1    <= 2'd0;
            r_row_d2    <= 2'd0;
            r_row_d3    <= 2'd0;
            r_line_d1   <= 4'd0;
            r_line_d2   <= 4'd0;
            r_char_xy   <= 8'h00;
            r_sync_d1   <= '0;
            r_sync_d2   <= '0;
            r_sync_d3   <= '0;
            r_sync_d4   <= '0;
            r_rgb_d1    <= 12'h000;
            r_rgb_d2    <= 12'h000;
            r_rgb_d3    <= 12'h000;
            r_rgb_out   <= 12'h000;
        end else begin
            r_in_box_d1 <= w_in_box;
            r_in_box_d2 <= r_in_box_d1;
            r_in_box_d3 <= r_in_box_d2;
            r_rel_x_d1  <= w_dx[2:0];
            r_rel_x_d2  <= r_rel_x_d1;
            r_rel_x_d3  <= r_rel_x_d2;
            r_row_d1    <= w_dy[5:4];
            r_row_d2    <= r_row_d1;
            r_row_d3    <= r_row_d2;
            r_line_d1   <= w_dy[3:0];
            r_line_d2   <= r_line_d1;
            r_char_xy   <= w_in_box ? {2'b00, w_dy[5:4], w_dx[6:3]} : 8'h00;
            r_sync_d1   <= w_sync_in;
            r_sync_d2   <= r_sync_d1;
            r_sync_d3   <= r_sync_d2;
            r_sync_d4   <= r_sync_d3;
            r_rgb_d1    <= rgb_in;
            r_rgb_d2    <= r_rgb_d1;
            r_rgb_d3    <= r_rgb_d2;
            r_rgb_out   <= w_rgb_next;
        end
    end

    // Highlight settings are sampled only at the start of a frame so a row change never tears.
    assign w_vs_rise = vsync_in & ~r_vsync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q     <= 1'b0;
            r_frame_cnt   <= 6'd0;
            r_blink_phase <= 1'b0;
            r_hl_row      <= 2'd0;
            r_hl_en       <= 1'b0;
        end else begin
            r_vsync_q <= vsync_in;
            if (w_vs_rise) begin
                r_hl_row <= sel_row;
                r_hl_en  <= sel_en;
                if (r_frame_cnt == BLINK_FRAMES - 6'd1) begin
                    r_frame_cnt   <= 6'd0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end
        end
    end

    assign w_glyph_bit = char_pixels[3'd7 - r_rel_x_d3];
    assign w_blank     = r_sync_d3[1] | r_sync_d3[0];

    always_comb begin
        w_rgb_next = r_rgb_d3;
        if (w_blank) begin
            w_rgb_next = 12'h000;
        end else if (r_in_box_d3 && w_glyph_bit) begin
            if (r_hl_en && (r_row_d3 == r_hl_row) && r_blink_phase)
                w_rgb_next = HL_COLOR;
            else
                w_rgb_next = TXT_COLOR;
        end
    end

    assign char_xy    = r_char_xy;
    assign font_addr  = {char_code, r_line_d2};
    assign hcount_out = r_sync_d4[25:15];
    assign vcount_out = r_sync_d4[14:4];
    assign hsync_out  = r_sync_d4[3];
    assign vsync_out  = r_sync_d4[2];
    assign hblnk_out  = r_sync_d4[1];
    assign vblnk_out  = r_sync_d4[0];
    assign rgb_out    = r_rgb_out;

endmodule
